main_memory_responder: RTL and testbench
========================================

// Module: main_memory_responder
// PURPOSE
// - Memory-side responder for the L2 cache mem_* interface (mem_read/mem_write/mem_addr/mem_wdata -> mem_rdata/mem_ready).
// - Behavioural main memory: 128-bit block storage with fixed, programmable access latency.
// - Acts as the slave end of the L2 initiator protocol; sits below L2_Cache in the system and in the L2 bench.
// PARAMETERS
// - ADDR_W   28    block address width; matches mem_addr.
// - DEPTH    1024  number of 128-bit blocks; power of 2; indexed by mem_addr[log2(DEPTH)-1:0], upper bits ignored.
// - LATENCY  4     cycles from request-visible to mem_ready; legal range 1..255.
// PORTS
// - clk           in   1        system clock, rising edge.
// - reset_n       in   1        asynchronous, active-low reset.
// - mem_read      in   1        read request; held by initiator until mem_ready seen.
// - mem_write     in   1        write request; held by initiator until mem_ready seen.
// - mem_addr      in   ADDR_W   block address; stable while request held.
// - mem_wdata     in   128      write block; stable while mem_write held.
// - mem_rdata     out  128      read block; valid only in the mem_ready cycle of a read.
// - mem_ready     out  1        one-cycle completion pulse.
// - protocol_err  out  1        sticky; set on mem_read & mem_write both high at accept.
// - rd_count      out  32       completed reads (MEM_STATS_EN only).
// - wr_count      out  32       completed writes (MEM_STATS_EN only).
// BEHAVIOUR
// - Reset (reset_n=0, async): state IDLE, mem_ready=0, mem_rdata=0, protocol_err=0, counters=0, latency counter=0, every array entry=0.
// - States: IDLE -> BUSY -> RESP -> IDLE. All outputs registered.
// - IDLE: request (mem_read|mem_write) high in cycle T -> capture addr, wdata, op (write if mem_write); load counter=LATENCY-1.
//   If LATENCY=1, go directly to RESP; else go to BUSY.
// - BUSY: decrement each cycle; when counter reaches 0, go to RESP.
//   mem_ready is high exactly in cycle T+LATENCY.
// - RESP: mem_ready=1 for one cycle.
//   Read: mem_rdata = array[captured idx] for that cycle.
//   Write: array[idx] <= captured wdata at the end of that cycle.
//   Request inputs are ignored in RESP, even though the initiator still holds them. Next state is IDLE.
// - Outside RESP: mem_ready=0 and mem_rdata=0.
// - Back-to-back: a new request visible in cycle T+LATENCY+1 (L2 write-back then refill) is accepted in IDLE with no bubble.
//   A read to a just-written block returns the new data.
// - Both mem_read and mem_write high at accept: treated as write; protocol_err set and held until reset.
// - Request dropped or address changed during BUSY: the captured transaction still completes normally; no abort.
// - reset_n asserted mid-transaction: transaction discarded, array cleared, no mem_ready issued.
// - No request in IDLE: remain IDLE, outputs 0.
// CONFIGURATION
// - MEM_STATS_EN defined:
//   rd_count/wr_count increment by 1 in the RESP cycle of each read/write.
//   Both wrap at 2^32-1 -> 0.
// - MEM_STATS_EN undefined: counters not built; rd_count/wr_count tied to 0; ports still present.
// TESTING
// - Write then read, LATENCY=4: write addr 0x0000005, wdata 0xDEADBEEF_...01; ready in cycle T+4.
//   Read of the same addr -> ready at T'+4, mem_rdata = that data.
// - Read of an untouched addr after reset -> mem_rdata=0 in ready cycle; mem_ready high for exactly 1 cycle.
// - Back-to-back L2 eviction: write addr A accepted at T, read addr B raised at T+5.
//   -> read accepted with no idle gap; ready at T+9 with array[B].
// - mem_read=mem_write=1 at accept -> handled as write; protocol_err=1 and stays 1 until reset_n low.
// - reset_n pulsed low during BUSY -> mem_ready never pulses; array reads back 0 afterwards.
// - LATENCY=1 and aliasing: addr 0x0000400 with DEPTH=1024 hits entry 0; ready in cycle T+1.
//   With MEM_STATS_EN: after 3 reads and 2 writes, rd_count=3, wr_count=2.

Source files
------------

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - fixed-latency 128-bit block memory responder for the L2 mem_* port
// Optional read/write completion counters are built when MEM_STATS_EN is defined.
module main_memory_responder #(
    parameter int ADDR_W  = 28,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_wdata,
    output logic [127:0]      mem_rdata,
    output logic              mem_ready,
    output logic              protocol_err,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);
    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [127:0]     wdata_q, wdata_d;
    logic             is_wr_q, is_wr_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic [127:0]     rdata_q, rdata_d;
    logic [127:0]     mem_q [DEPTH];

    generate
        if (ADDR_W > IDX_W) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
        end
    end

    // Request inputs are only looked at in IDLE; BUSY/RESP run on the captured copy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d   = mem_addr[IDX_W-1:0];
                    wdata_d = mem_wdata;
                    is_wr_d = mem_write;
                    err_d   = err_q | (mem_read & mem_write);
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d = (state_d == RESP);
        rdata_d = '0;
        if ((state_d == RESP) && !is_wr_d) begin
            rdata_d = mem_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Write commits at the end of RESP so a following read sees the new block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if ((state_q == RESP) && is_wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_d == RESP) begin
            if (is_wr_d) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

    assign mem_ready    = ready_q;
    assign mem_rdata    = rdata_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - randomized scoreboard bench for main_memory_responder
module tb_main_memory_responder;
    localparam int ADDR_W = 28;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 4;
    localparam int IDX_W  = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [127:0]      mem_wdata = '0;
    logic [127:0]      mem_rdata;
    logic              mem_ready;
    logic              protocol_err;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    main_memory_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .protocol_err(protocol_err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_read;
        logic [127:0] data;
        int           due;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [127:0] model_mem [DEPTH];
    logic         model_err = 1'b0;
    int unsigned  rd_m = 0;
    int unsigned  wr_m = 0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_err = 1'b0;
        rd_m = 0;
        wr_m = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {127'b0, mem_ready}, 128'd0);
        check({tag, "_rdata"}, mem_rdata, 128'd0);
        check({tag, "_err"}, {127'b0, protocol_err}, 128'd0);
        check({tag, "_rd_count"}, {96'b0, rd_count}, 128'd0);
        check({tag, "_wr_count"}, {96'b0, wr_count}, 128'd0);
    endtask

    task automatic check_stats();
`ifdef MEM_STATS_EN
        check("rd_count", {96'b0, rd_count}, {96'b0, rd_m});
        check("wr_count", {96'b0, wr_count}, {96'b0, wr_m});
`else
        check("rd_count", {96'b0, rd_count}, 128'd0);
        check("wr_count", {96'b0, wr_count}, 128'd0);
`endif
    endtask

    // Drive one request in the next cycle and hold it until mem_ready is seen.
    task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [127:0] d, input bit scramble);
        exp_t        e;
        int          n;
        int unsigned r;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        e.due     = cyc + LAT;
        e.is_read = !wr;
        e.data    = model_mem[a % DEPTH];
        if (wr) begin
            model_mem[a % DEPTH] = d;
            wr_m++;
        end else begin
            rd_m++;
        end
        if (rd && wr) model_err = 1'b1;
        e.err = model_err;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && !mem_ready) begin
                r         = $urandom();
                mem_addr  = r[ADDR_W-1:0];
                mem_read  = 1'b0;
                mem_write = 1'b0;
                mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end while (!mem_ready && n < 4 * LAT + 10);
        if (!mem_ready) check("ready_timeout", {127'b0, mem_ready}, 128'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ready", {127'b0, mem_ready}, 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ready_cycle", 128'(cyc), 128'(mon_e.due));
                    if (mon_e.is_read) check("rdata", mem_rdata, mon_e.data);
                    check("protocol_err", {127'b0, protocol_err}, {127'b0, mon_e.err});
                end
            end else begin
                check("rdata_idle_zero", mem_rdata, 128'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned r, r2;
        logic [ADDR_W-1:0] a;
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_idle_outputs("reset");
        reset_n = 1'b1;
        idle(2);

        issue(1'b0, 1'b1, 28'h0000005, 128'hDEADBEEF_00000000_00000000_00000001, 1'b0);
        issue(1'b1, 1'b0, 28'h0000005, '0, 1'b0);
        issue(1'b1, 1'b0, 28'h0000123, '0, 1'b0);
        issue(1'b0, 1'b1, 28'h0000400, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 1'b0);
        issue(1'b1, 1'b0, 28'h0000000, '0, 1'b0);
        issue(1'b1, 1'b0, 28'h0000005, '0, 1'b1);
        idle(2);

        for (int i = 0; i < 200; i++) begin
            r  = $urandom();
            r2 = $urandom_range(0, 15);
            a  = {r[ADDR_W-1:IDX_W], IDX_W'(r2)};
            idle($urandom_range(0, 2));
            if (i == 100)
                issue(1'b1, 1'b1, a, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
            else if ($urandom_range(0, 1) == 0)
                issue(1'b1, 1'b0, a, '0, ($urandom_range(0, 3) == 0));
            else
                issue(1'b0, 1'b1, a, {$urandom(), $urandom(), $urandom(), $urandom()},
                      ($urandom_range(0, 3) == 0));
        end
        idle(3);
        check("err_sticky", {127'b0, protocol_err}, 128'd1);
        check_stats();

        // Reset in the middle of a read: no completion may appear afterwards.
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 28'h0000005;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        reset_n  = 1'b1;
        mem_read = 1'b0;
        idle(LAT + 4);

        issue(1'b1, 1'b0, 28'h0000005, '0, 1'b0);
        issue(1'b1, 1'b0, 28'h0000400, '0, 1'b0);
        issue(1'b0, 1'b1, 28'h0000007, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        issue(1'b0, 1'b1, 28'h0000407, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
        issue(1'b1, 1'b0, 28'h0000007, '0, 1'b0);
        idle(3);
        check("err_after_reset", {127'b0, protocol_err}, 128'd0);
        check_stats();
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
